// File: rtl/eth_block_lock_ctrl.sv
// -----------------------------------------------------------------------------
// eth_block_lock_ctrl
//
// 64b/66b receive block-lock state machine. Tests sync headers in windows of
// SH_CNT_MAX header events. While unlocked, any invalid header requests a
// bitslip from the gearbox. Lock is declared after a full window of valid
// headers. While locked, lock is dropped and a slip is requested as soon as
// SH_INVALID_MAX invalid headers have been seen within one window. After each
// slip, headers are ignored for SLIP_WAIT cycles while the gearbox realigns.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset (release pre-synchronised)
//   i_enable         1 = run lock search, 0 = hold in RESET_CNT with lock low
//   i_data_valid     gearbox beat valid
//   i_header         2-bit sync header of the current block
//   i_header_valid   i_header belongs to this beat
//   o_slip           one-cycle bitslip request
//   o_block_lock     block lock achieved
//   o_state          0 RESET_CNT, 1 TEST, 2 SLIP_WAIT
//   o_lock_loss_cnt  saturating count of lock-loss events
// -----------------------------------------------------------------------------
module eth_block_lock_ctrl #(
    parameter int unsigned SH_CNT_MAX     = 64,
    parameter int unsigned SH_INVALID_MAX = 16,
    parameter int unsigned SLIP_WAIT      = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_data_valid,
    input  logic [1:0]  i_header,
    input  logic        i_header_valid,
    output logic        o_slip,
    output logic        o_block_lock,
    output logic [1:0]  o_state,
    output logic [15:0] o_lock_loss_cnt
);

    localparam int unsigned CNT_W = $clog2(SH_CNT_MAX + 1);
    localparam int unsigned INV_W = $clog2(SH_INVALID_MAX + 1);
    localparam int unsigned TMR_W = $clog2(SLIP_WAIT + 1);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(SH_CNT_MAX);
    localparam logic [INV_W-1:0] INV_LIMIT = INV_W'(SH_INVALID_MAX);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(SLIP_WAIT);

    typedef enum logic [1:0] {
        ST_RESET_CNT = 2'd0,
        ST_TEST      = 2'd1,
        ST_SLIP_WAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] sh_cnt_q, sh_cnt_d;
    logic [INV_W-1:0] sh_invalid_cnt_q, sh_invalid_cnt_d;
    logic [TMR_W-1:0] slip_timer_q, slip_timer_d;
    logic             slip_q, slip_d;
    logic             block_lock_q, block_lock_d;
    logic [15:0]      lock_loss_cnt_q, lock_loss_cnt_d;

    logic             hdr_event;
    logic             hdr_ok;
    logic [CNT_W-1:0] sh_cnt_inc;
    logic [INV_W-1:0] sh_invalid_inc;

    assign hdr_event      = i_data_valid & i_header_valid;
    // Only 01 and 10 are legal sync headers, i.e. the two bits differ.
    assign hdr_ok         = i_header[1] ^ i_header[0];
    // Stored counts stay below their limits, so the +1 never overflows.
    assign sh_cnt_inc     = sh_cnt_q + CNT_W'(1);
    assign sh_invalid_inc = sh_invalid_cnt_q + INV_W'(!hdr_ok);

    // NOTE: every _d gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d          = state_q;
        sh_cnt_d         = sh_cnt_q;
        sh_invalid_cnt_d = sh_invalid_cnt_q;
        slip_timer_d     = slip_timer_q;
        slip_d           = 1'b0;
        block_lock_d     = block_lock_q;
        lock_loss_cnt_d  = lock_loss_cnt_q;

        if (!i_enable) begin
            // Disabling is not a lock loss: no slip, no loss count.
            state_d      = ST_RESET_CNT;
            block_lock_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_RESET_CNT: begin
                    sh_cnt_d         = '0;
                    sh_invalid_cnt_d = '0;
                    state_d          = ST_TEST;
                end

                ST_TEST: begin
                    if (hdr_event) begin
                        sh_cnt_d = sh_cnt_inc;
                        if (!block_lock_q) begin
                            if (!hdr_ok) begin
                                slip_d       = 1'b1;
                                slip_timer_d = TMR_LOAD;
                                state_d      = ST_SLIP_WAIT;
                            end else if (sh_cnt_inc == CNT_LIMIT) begin
                                block_lock_d = 1'b1;
                                state_d      = ST_RESET_CNT;
                            end
                        end else begin
                            sh_invalid_cnt_d = sh_invalid_inc;
                            // Invalid limit is checked first so it wins over a
                            // window ending on the same event.
                            if (!hdr_ok && (sh_invalid_inc == INV_LIMIT)) begin
                                block_lock_d = 1'b0;
                                slip_d       = 1'b1;
                                slip_timer_d = TMR_LOAD;
                                state_d      = ST_SLIP_WAIT;
                                if (lock_loss_cnt_q != 16'hFFFF) begin
                                    lock_loss_cnt_d = lock_loss_cnt_q + 16'd1;
                                end
                            end else if (sh_cnt_inc == CNT_LIMIT) begin
                                state_d = ST_RESET_CNT;
                            end
                        end
                    end
                end

                ST_SLIP_WAIT: begin
                    // Counts down every cycle; leaving as it reaches zero
                    // gives exactly SLIP_WAIT cycles in this state.
                    slip_timer_d = slip_timer_q - TMR_W'(1);
                    if (slip_timer_q <= TMR_W'(1)) begin
                        state_d = ST_RESET_CNT;
                    end
                end

                default: begin
                    state_d = ST_RESET_CNT;
                end
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; the reset branch is asynchronous via the sensitivity list.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q          <= ST_RESET_CNT;
            sh_cnt_q         <= '0;
            sh_invalid_cnt_q <= '0;
            slip_timer_q     <= '0;
            slip_q           <= 1'b0;
            block_lock_q     <= 1'b0;
            lock_loss_cnt_q  <= '0;
        end else begin
            state_q          <= state_d;
            sh_cnt_q         <= sh_cnt_d;
            sh_invalid_cnt_q <= sh_invalid_cnt_d;
            slip_timer_q     <= slip_timer_d;
            slip_q           <= slip_d;
            block_lock_q     <= block_lock_d;
            lock_loss_cnt_q  <= lock_loss_cnt_d;
        end
    end

    assign o_slip          = slip_q;
    assign o_block_lock    = block_lock_q;
    assign o_state         = state_q;
    assign o_lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_eth_block_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eth_block_lock_ctrl
//
// Self-checking bench for eth_block_lock_ctrl with default parameters.
// A short vector table covers basic event qualification, directed sequences
// cover the window/lock corner cases, and a randomized phase is compared every
// cycle against a window-list reference model.
// -----------------------------------------------------------------------------
module tb_eth_block_lock_ctrl;

    localparam int SH_CNT_MAX     = 64;
    localparam int SH_INVALID_MAX = 16;
    localparam int SLIP_WAIT      = 32;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_enable;
    logic        i_data_valid;
    logic [1:0]  i_header;
    logic        i_header_valid;
    logic        o_slip;
    logic        o_block_lock;
    logic [1:0]  o_state;
    logic [15:0] o_lock_loss_cnt;

    eth_block_lock_ctrl #(
        .SH_CNT_MAX    (SH_CNT_MAX),
        .SH_INVALID_MAX(SH_INVALID_MAX),
        .SLIP_WAIT     (SLIP_WAIT)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_enable       (i_enable),
        .i_data_valid   (i_data_valid),
        .i_header       (i_header),
        .i_header_valid (i_header_valid),
        .o_slip         (o_slip),
        .o_block_lock   (o_block_lock),
        .o_state        (o_state),
        .o_lock_loss_cnt(o_lock_loss_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase numbers follow the o_state encoding; the window is kept as a list
    // of per-event "bad header" flags and its length/bad count derived from it.
    int m_state;
    int m_wait;
    bit m_lock;
    bit m_slip;
    int m_loss;
    bit window[$];

    function automatic void model_reset();
        m_state = 0;
        m_wait  = 0;
        m_lock  = 0;
        m_slip  = 0;
        m_loss  = 0;
        window.delete();
    endfunction

    function automatic void model_step(input bit en, input bit dv, input bit hv, input bit [1:0] hdr);
        bit bad;
        int nbad;
        m_slip = 0;
        if (!en) begin
            m_state = 0;
            m_lock  = 0;
            return;
        end
        case (m_state)
            0: begin
                window.delete();
                m_state = 1;
            end
            1: begin
                if (dv && hv) begin
                    bad = (hdr == 2'b00) || (hdr == 2'b11);
                    window.push_back(bad);
                    nbad = 0;
                    foreach (window[i]) nbad += int'(window[i]);
                    if (!m_lock) begin
                        if (bad) begin
                            m_slip = 1; m_wait = SLIP_WAIT; m_state = 2;
                        end else if (window.size() == SH_CNT_MAX) begin
                            m_lock = 1; m_state = 0;
                        end
                    end else begin
                        if (bad && nbad == SH_INVALID_MAX) begin
                            m_lock = 0; m_slip = 1; m_wait = SLIP_WAIT; m_state = 2;
                            if (m_loss < 65535) m_loss++;
                        end else if (window.size() == SH_CNT_MAX) begin
                            m_state = 0;
                        end
                    end
                end
            end
            default: begin
                m_wait--;
                if (m_wait == 0) m_state = 0;
            end
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick(input bit en, input bit dv, input bit hv, input bit [1:0] hdr);
        i_enable       = en;
        i_data_valid   = dv;
        i_header_valid = hv;
        i_header       = hdr;
        @(posedge i_clk);
        model_step(en, dv, hv, hdr);
        #1;
        check("model_state", o_state, m_state);
        check("model_lock", o_block_lock, m_lock);
        check("model_slip", o_slip, m_slip);
        check("model_loss", o_lock_loss_cnt, m_loss);
    endtask

    task automatic ev(input bit [1:0] hdr);
        tick(1'b1, 1'b1, 1'b1, hdr);
    endtask

    task automatic idle();
        tick(1'b1, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic wait_state(input int s, input int budget);
        int n = 0;
        while (int'(o_state) != s && n < budget) begin
            idle();
            n++;
        end
        check("wait_state", o_state, s);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_state", o_state, 0);
        check("rst_lock", o_block_lock, 0);
        check("rst_slip", o_slip, 0);
        check("rst_loss", o_lock_loss_cnt, 0);
        i_rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit       en;
        bit       dv;
        bit       hv;
        bit [1:0] hdr;
        int       st;
        bit       lk;
        bit       sl;
    } vec_t;

    vec_t vecs[10];
    int   rates[6] = '{0, 20, 3, 50, 0, 25};

    initial begin
        bit slip_any;
        int n2;

        i_rst_n        = 1'b0;
        i_enable       = 1'b0;
        i_data_valid   = 1'b0;
        i_header_valid = 1'b0;
        i_header       = 2'b00;

        //            en dv hv hdr    st lk sl
        vecs[0] = '{1'b0, 1'b0, 1'b0, 2'b00, 0, 1'b0, 1'b0}; // disabled: hold
        vecs[1] = '{1'b1, 1'b0, 1'b0, 2'b00, 1, 1'b0, 1'b0}; // RESET_CNT -> TEST
        vecs[2] = '{1'b1, 1'b1, 1'b1, 2'b01, 1, 1'b0, 1'b0}; // valid header
        vecs[3] = '{1'b1, 1'b0, 1'b1, 2'b00, 1, 1'b0, 1'b0}; // no beat: ignored
        vecs[4] = '{1'b1, 1'b1, 1'b0, 2'b11, 1, 1'b0, 1'b0}; // no header: ignored
        vecs[5] = '{1'b1, 1'b1, 1'b1, 2'b11, 2, 1'b0, 1'b1}; // invalid: slip
        vecs[6] = '{1'b1, 1'b1, 1'b1, 2'b00, 2, 1'b0, 1'b0}; // ignored in wait
        vecs[7] = '{1'b0, 1'b0, 1'b0, 2'b00, 0, 1'b0, 1'b0}; // disable aborts wait
        vecs[8] = '{1'b1, 1'b0, 1'b0, 2'b00, 1, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b1, 1'b1, 2'b10, 1, 1'b0, 1'b0};

        #2;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            tick(vecs[i].en, vecs[i].dv, vecs[i].hv, vecs[i].hdr);
            check($sformatf("vec%0d_state", i), o_state, vecs[i].st);
            check($sformatf("vec%0d_lock", i), o_block_lock, vecs[i].lk);
            check($sformatf("vec%0d_slip", i), o_slip, vecs[i].sl);
        end

        // Clean lock: 64 valid headers, lock one cycle after the 64th.
        do_reset();
        idle();
        slip_any = 0;
        for (int k = 1; k <= SH_CNT_MAX; k++) begin
            ev(2'b10);
            slip_any |= o_slip;
            if (k == SH_CNT_MAX - 1) check("lock_before_64", o_block_lock, 0);
        end
        check("lock_at_64", o_block_lock, 1);
        check("lock_no_slip", slip_any, 0);

        // Locked window with 15 invalid: lock held.
        idle();
        for (int k = 1; k <= SH_CNT_MAX; k++) begin
            if (k <= SH_INVALID_MAX - 1) ev((k % 2) ? 2'b00 : 2'b11);
            else ev(2'b10);
        end
        check("hold15_lock", o_block_lock, 1);
        check("hold15_loss", o_lock_loss_cnt, 0);
        check("hold15_state", o_state, 0);

        // Locked window with 16th invalid at event 40: lock lost there.
        idle();
        for (int k = 1; k <= 40; k++) ev((k >= 25) ? 2'b11 : 2'b01);
        check("loss40_lock", o_block_lock, 0);
        check("loss40_slip", o_slip, 1);
        check("loss40_cnt", o_lock_loss_cnt, 1);
        check("loss40_state", o_state, 2);
        wait_state(1, 40);

        // Unlocked: 10 valid then invalid -> slip, 32 cycles of SLIP_WAIT.
        for (int k = 0; k < 10; k++) ev(2'b01);
        ev(2'b11);
        check("unl_slip", o_slip, 1);
        check("unl_state", o_state, 2);
        n2 = 1;
        while (o_state == 2'd2 && n2 < 40) begin
            idle();
            if (o_state == 2'd2) n2++;
        end
        check("slip_wait_len", n2, SLIP_WAIT);
        check("after_wait_state", o_state, 0);
        idle();
        check("retest_state", o_state, 1);

        // Relock, then 16th invalid lands on the 64th event: limit wins.
        for (int k = 1; k <= SH_CNT_MAX; k++) ev(2'b10);
        check("relock", o_block_lock, 1);
        idle();
        for (int k = 1; k <= SH_CNT_MAX; k++) ev((k > SH_CNT_MAX - SH_INVALID_MAX) ? 2'b00 : 2'b01);
        check("tie_lock", o_block_lock, 0);
        check("tie_slip", o_slip, 1);
        check("tie_cnt", o_lock_loss_cnt, 2);

        // Header flagged but no data beat: nothing happens.
        wait_state(1, 40);
        slip_any = 0;
        for (int k = 0; k < 100; k++) begin
            tick(1'b1, 1'b0, 1'b1, 2'b00);
            slip_any |= o_slip;
        end
        check("nobeat_slip", slip_any, 0);
        check("nobeat_state", o_state, 1);

        // Third lock loss, then async reset mid-SLIP_WAIT.
        for (int k = 1; k <= SH_CNT_MAX; k++) ev(2'b01);
        idle();
        for (int k = 1; k <= SH_INVALID_MAX; k++) ev(2'b11);
        check("loss3_cnt", o_lock_loss_cnt, 3);
        repeat (3) idle();
        check("pre_arst_state", o_state, 2);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_state", o_state, 0);
        check("arst_lock", o_block_lock, 0);
        check("arst_slip", o_slip, 0);
        check("arst_loss", o_lock_loss_cnt, 0);
        model_reset();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // Reset mid-window discards progress.
        idle();
        for (int k = 0; k < 5; k++) ev(2'b10);
        do_reset();
        idle();
        for (int k = 1; k < SH_CNT_MAX; k++) ev(2'b10);
        check("midrst_nolock", o_block_lock, 0);
        ev(2'b10);
        check("midrst_lock", o_block_lock, 1);

        // Randomized segments with varying invalid-header rates (percent).
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < 1000; c++) begin
                bit en_r, dv_r, hv_r;
                bit [1:0] hdr_r;
                en_r = ($urandom_range(999) >= 3);
                dv_r = ($urandom_range(99) < 80);
                hv_r = ($urandom_range(99) < 70);
                if ($urandom_range(99) < rates[s]) hdr_r = $urandom_range(1) ? 2'b00 : 2'b11;
                else hdr_r = $urandom_range(1) ? 2'b01 : 2'b10;
                tick(en_r, dv_r, hv_r, hdr_r);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/eth_block_lock_ctrl.md
ETH_BLOCK_LOCK_CTRL -- requirements
Module: eth_block_lock_ctrl

Interface
REQ-001 Parameter SH_CNT_MAX, default 64: sync headers per test window; 2..1023.
REQ-002 Parameter SH_INVALID_MAX, default 16: invalid headers in a window that drop lock; 1..SH_CNT_MAX.
REQ-003 Parameter SLIP_WAIT, default 32: cycles headers are ignored after a slip pulse; 1..255.
REQ-004 i_clk  input  1  clock; all logic on rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_enable  input  1  1 = run lock search; 0 = hold in RESET_CNT, lock deasserted.
REQ-007 i_data_valid  input  1  gearbox beat valid; header sampled only when high.
REQ-008 i_header  input  2  66b sync header of current block.
REQ-009 i_header_valid  input  1  i_header belongs to this beat (every other beat on 32-bit path).
REQ-010 o_slip  output  1  one-cycle bitslip request to gearbox.
REQ-011 o_block_lock  output  1  block lock achieved; gates the downstream rx interface.
REQ-012 o_state  output  2  current FSM state: 0 RESET_CNT, 1 TEST, 2 SLIP_WAIT.
REQ-013 o_lock_loss_cnt  output  16  lock-loss events, saturating at 16'hFFFF.

Function
REQ-014 Header event = i_data_valid && i_header_valid; all other cycles leave counters unchanged.
REQ-015 Header valid iff i_header is 2'b01 or 2'b10; 2'b00, 2'b11 invalid.
REQ-016 Counters: sh_cnt (tested headers), sh_invalid_cnt (invalid in window), slip_timer; widths $clog2(max+1).
REQ-017 RESET_CNT: clear sh_cnt, sh_invalid_cnt; next cycle -> TEST if i_enable, else stay.
REQ-018 TEST, unlocked: each header event increments sh_cnt; invalid header -> o_slip=1 that cycle, load slip_timer=SLIP_WAIT, -> SLIP_WAIT.
REQ-019 TEST, unlocked: header event making sh_cnt==SH_CNT_MAX with all valid -> o_block_lock=1 next cycle, -> RESET_CNT.
REQ-020 TEST, locked: invalid header increments sh_invalid_cnt; reaching SH_INVALID_MAX -> o_block_lock=0, o_slip=1, o_lock_loss_cnt+1, -> SLIP_WAIT (same edge).
REQ-021 TEST, locked: sh_cnt reaching SH_CNT_MAX with sh_invalid_cnt<SH_INVALID_MAX (after that event) -> stay locked, -> RESET_CNT.
REQ-022 Simultaneous window end and invalid-limit on one event: limit wins (lock lost, slip).
REQ-023 SLIP_WAIT: slip_timer decrements every cycle regardless of i_data_valid; header events ignored; at 0 -> RESET_CNT.
REQ-024 o_slip registered, high exactly one cycle per slip; never high in RESET_CNT or SLIP_WAIT except the entry cycle's registered pulse.
REQ-025 o_slip deasserted and no counter change when i_enable=0; i_enable falling in any state -> o_block_lock=0 next cycle, -> RESET_CNT, no lock-loss count.
REQ-026 o_lock_loss_cnt saturates; no wrap at 16'hFFFF.
REQ-027 Latency: header event to o_slip/o_block_lock change = 1 cycle.

Reset
REQ-028 On i_rst_n low, asynchronously: state RESET_CNT, o_slip=0, o_block_lock=0, o_lock_loss_cnt=0, all counters 0.
REQ-029 Reset mid-SLIP_WAIT or mid-window discards progress; first header after release counts as sh_cnt=1 after one RESET_CNT cycle.
REQ-030 Release of i_rst_n synchronised to i_clk by the instantiating top level; block adds no synchroniser.

Verification
REQ-031 Defaults, enable=1, 64 header events all 2'b10 -> o_block_lock=1 one cycle after 64th event, o_slip never high.
REQ-032 Unlocked, 10 valid then header 2'b11 -> o_slip high 1 cycle, o_state=2 for 32 cycles, then 0, then 1; sh_cnt restarts.
REQ-033 Locked, window with 15 invalid among 64 -> lock held; window with 16th invalid at event 40 -> lock drops, o_slip pulse, o_lock_loss_cnt=1.
REQ-034 Locked, 16th invalid on 64th event -> lock lost (REQ-022), o_lock_loss_cnt increments.
REQ-035 i_header_valid=1 with i_data_valid=0 on 2'b00 for 100 cycles -> no slip, no count change.
REQ-036 Assert i_rst_n low in SLIP_WAIT with o_lock_loss_cnt=3 -> all outputs 0 immediately, without clock edge.
